probe_capture: RTL

Parametrised on-chip trigger-and-capture core, the next generation of the fixed-probe watcher used for board bring-up. It registers a PROBE_W-bit probe bus every clock and stores it in a DEPTH-entry circular buffer. It freezes the buffer after a programmable trigger with PRE_TRIG samples of history. A host-side reader (UART/JTAG bridge) then reads the buffer through a synchronous read port.

---
 rtl/probe_capture.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/probe_capture.sv
// Trigger-and-capture core: circular probe buffer frozen PRE_TRIG samples before a trigger.
// Define PROBE_CAPTURE_EDGE_TRIG_EN to add per-bit edge qualification of the trigger.
module probe_capture #(
  parameter int PROBE_W  = 64,
  parameter int DEPTH    = 1024,
  parameter int PRE_TRIG = 256,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PROBE_W-1:0] probe,
  input  logic               arm,
  input  logic               abort,
  input  logic [PROBE_W-1:0] trig_mask,
  input  logic [PROBE_W-1:0] trig_value,
  input  logic [PROBE_W-1:0] trig_edge,
  output logic               busy,
  output logic               triggered,
  output logic               done,
  output logic [AW-1:0]      trig_ptr,
  output logic [AW-1:0]      start_ptr,
  input  logic [AW-1:0]      rd_addr,
  output logic [PROBE_W-1:0] rd_data
);

  localparam int PRE_LAST_I = (PRE_TRIG > 0) ? PRE_TRIG - 1 : 0;
  localparam int POST_I     = DEPTH - PRE_TRIG - 1;
  localparam logic [AW-1:0] PRE_LAST = PRE_LAST_I[AW-1:0];
  localparam logic [AW-1:0] POST_N   = POST_I[AW-1:0];
  localparam logic [AW-1:0] PRE_OFF  = PRE_TRIG[AW-1:0];
  localparam logic [AW-1:0] ONE      = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

  state_t             state;
  logic [PROBE_W-1:0] probe_q;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      pre_cnt;
  logic [AW-1:0]      post_cnt;
  logic               level_hit;
  logic               hit;
  logic               wr_en;
  logic [PROBE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) probe_q <= '0;
    else        probe_q <= probe;
  end

  assign level_hit = (((probe_q ^ trig_value) & trig_mask) == '0);

`ifdef PROBE_CAPTURE_EDGE_TRIG_EN
  logic [PROBE_W-1:0] probe_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) probe_p <= '0;
    else        probe_p <= probe_q;
  end

  // Edge-qualified bits fail while they hold the same level as last cycle.
  assign hit = level_hit && ((~(probe_p ^ probe_q) & trig_mask & trig_edge) == '0);
`else
  logic unused_edge;
  assign unused_edge = ^trig_edge;
  assign hit = level_hit;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      busy      <= 1'b0;
      triggered <= 1'b0;
      done      <= 1'b0;
      trig_ptr  <= '0;
      start_ptr <= '0;
    end else if (abort) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            wr_ptr    <= '0;
            pre_cnt   <= '0;
            triggered <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b1;
            state     <= (PRE_TRIG == 0) ? S_WAIT : S_PRE;
          end
        end
        S_PRE: begin
          wr_ptr  <= wr_ptr + ONE;
          pre_cnt <= pre_cnt + ONE;
          if (pre_cnt == PRE_LAST) state <= S_WAIT;
        end
        S_WAIT: begin
          wr_ptr <= wr_ptr + ONE;
          if (hit) begin
            triggered <= 1'b1;
            trig_ptr  <= wr_ptr;
            post_cnt  <= POST_N;
            if (POST_N == '0) begin
              state     <= S_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              start_ptr <= wr_ptr - PRE_OFF;
            end else begin
              state <= S_POST;
            end
          end
        end
        S_POST: begin
          wr_ptr   <= wr_ptr + ONE;
          post_cnt <= post_cnt - ONE;
          if (post_cnt == ONE) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            start_ptr <= trig_ptr - PRE_OFF;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // An abort cycle stores nothing, so the buffer freezes with the state.
  assign wr_en = !abort && ((state == S_PRE) || (state == S_WAIT) || (state == S_POST));

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= probe_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end

endmodule
